// File: rtl/fifo_flags_pkg.sv
// ============================================================================
// fifo_flags_pkg : shared defaults and read-mode constants for fifo_flags
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_flags_pkg;

    localparam int DEF_D_W   = 8;
    localparam int DEF_AD_W  = 4;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// fifo_mem : DEPTH x D_W dual-port array, synchronous write, async read
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int D_W  = 8,
    parameter int AD_W = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AD_W-1:0] waddr,
    input  logic [D_W-1:0]  wdata,
    input  logic [AD_W-1:0] raddr,
    output logic [D_W-1:0]  rdata
);

    logic [D_W-1:0] mem_q [2**AD_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_flags.sv
// ============================================================================
// fifo_flags : synchronous FIFO with count, threshold and sticky error flags
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int D_W    = DEF_D_W,
    parameter int AD_W   = DEF_AD_W,
    parameter int AF_LVL = 2**AD_W - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = FIFO_STD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic          read,
    input  logic [D_W-1:0] data_in,
    input  logic          clr_err,
    output logic [D_W-1:0] data_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AD_W:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AD_W:0] c_AF_LVL = (AD_W+1)'(AF_LVL);
    localparam logic [AD_W:0] c_AE_LVL = (AD_W+1)'(AE_LVL);

    logic [AD_W:0]  wr_ptr_q, wr_ptr_d;
    logic [AD_W:0]  rd_ptr_q, rd_ptr_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           w_wr_acc;
    logic           w_rd_acc;
    logic [D_W-1:0] w_rdata;

    // Flags decode purely from registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AD_W] != rd_ptr_q[AD_W]) &&
                          (wr_ptr_q[AD_W-1:0] == rd_ptr_q[AD_W-1:0]);
    assign almost_full  = (count >= c_AF_LVL);
    assign almost_empty = (count <= c_AE_LVL);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign w_wr_acc = write && !full;
    assign w_rd_acc = read && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (w_wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        // A fresh error outranks a simultaneous clear.
        if (write && full)       ovf_d = 1'b1;
        else if (clr_err)        ovf_d = 1'b0;
        if (read && empty)       unf_d = 1'b1;
        else if (clr_err)        unf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .D_W  (D_W),
        .AD_W (AD_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (wr_ptr_q[AD_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[AD_W-1:0]),
        .rdata (w_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Zero while empty so the unwritten array never shows through.
            assign data_out = empty ? '0 : w_rdata;
        end else begin : g_std
            logic [D_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (w_rd_acc) begin
                    dout_q <= w_rdata;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

`default_nettype wire
